// File: rtl/uart_sim_monitor.sv
// 8N1 UART receiver with sticky "PASS"/"FAIL" marker detection on the received byte stream.
// rx_valid ~2 + ClksPerBit/2 + 9*ClksPerBit + 1 cycles after line falls; no backpressure (a pure line monitor).
module uart_sim_monitor #(
    parameter int unsigned ClockFrequency = 125_000_000,
    parameter int unsigned BaudRate       = 15_625_000,
    parameter int unsigned CountWidth     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  active_i,
    input  logic                  rx_i,
    output logic                  rx_valid_o,
    output logic [7:0]            rx_data_o,
    output logic                  frame_err_o,
    output logic [CountWidth-1:0] byte_count_o,
    output logic                  pass_o,
    output logic                  fail_o
);

    localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned CycW       = $clog2(ClksPerBit);

    if ((ClksPerBit * BaudRate != ClockFrequency) || (ClksPerBit < 4)) begin : g_bad_baud
        $error("uart_sim_monitor: ClockFrequency/BaudRate must be exact and >= 4");
    end

    localparam logic [CycW-1:0] LastCyc  = CycW'(ClksPerBit - 1);
    localparam logic [CycW-1:0] HalfCyc  = CycW'(ClksPerBit / 2 - 1);
    localparam logic [31:0]     PassWord = 32'h5041_5353;
    localparam logic [31:0]     FailWord = 32'h4641_494C;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic            rxs_prev;
    logic [CycW-1:0] cyc_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic [31:0]     history;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            rxs_prev     <= 1'b1;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            history      <= '0;
            rx_valid_o   <= 1'b0;
            rx_data_o    <= 8'h00;
            frame_err_o  <= 1'b0;
            byte_count_o <= '0;
            pass_o       <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rxs         <= rx_meta;
            rxs_prev    <= rxs;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;

            // History is already updated here, so a flag lands one cycle after its valid pulse.
            if ((history == PassWord) && !fail_o) begin
                pass_o <= 1'b1;
            end
            if ((history == FailWord) && !pass_o) begin
                fail_o <= 1'b1;
            end

            if (!active_i) begin
                state   <= IDLE;
                cyc_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxs_prev && !rxs) begin
                            state   <= START;
                            cyc_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    START: begin
                        if (cyc_cnt == HalfCyc) begin
                            cyc_cnt <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cyc_cnt == LastCyc) begin
                            cyc_cnt <= '0;
                            shift_q <= {rxs, shift_q[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cyc_cnt == LastCyc) begin
                            cyc_cnt <= '0;
                            if (rxs) begin
                                rx_valid_o <= 1'b1;
                                rx_data_o  <= shift_q;
                                history    <= {history[23:0], shift_q};
                                if (byte_count_o != '1) begin
                                    byte_count_o <= byte_count_o + 1'b1;
                                end
                                state <= IDLE;
                            end else begin
                                // A low stop bit may be a break; wait for the line to recover.
                                frame_err_o <= 1'b1;
                                state       <= WAIT_HIGH;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_sim_monitor.sv
// Scoreboard bench for uart_sim_monitor at 8 clocks per bit, 3-bit byte counter.
module tb_uart_sim_monitor;

    localparam int Cpb = 8;
    localparam int Cw  = 3;

    logic          clk_i    = 1'b0;
    logic          rst_ni   = 1'b0;
    logic          active_i = 1'b1;
    logic          rx_i     = 1'b1;
    logic          rx_valid_o;
    logic [7:0]    rx_data_o;
    logic          frame_err_o;
    logic [Cw-1:0] byte_count_o;
    logic          pass_o;
    logic          fail_o;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [8:0] tx_q[$];
    int         valid_cnt;
    int         err_cnt;
    int         first_lat;
    int         last_valid_cyc;
    int         pass_gap;
    int         fail_gap;

    always #4 clk_i = ~clk_i;

    uart_sim_monitor #(
        .ClockFrequency(125_000_000),
        .BaudRate      (15_625_000),
        .CountWidth    (Cw)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .active_i    (active_i),
        .rx_i        (rx_i),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .frame_err_o (frame_err_o),
        .byte_count_o(byte_count_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o)
    );

    task automatic align();
        @(posedge clk_i);
        #1;
    endtask

    task automatic hold_bits(input logic v, input int ncyc);
        rx_i = v;
        repeat (ncyc) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold_bits(1'b0, Cpb);
        for (int i = 0; i < 8; i++) hold_bits(b[i], Cpb);
        hold_bits(stop, Cpb);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back({1'b1, s[i]});
    endtask

    task automatic send_stream();
        logic [8:0] e;
        align();
        while (tx_q.size() > 0) begin
            e = tx_q.pop_front();
            if (e[8]) exp_q.push_back(e[7:0]);
            send_byte(e[7:0], e[8]);
        end
    endtask

    // Scoreboard side: pops one expected byte per valid pulse and tracks pulses/flag timing.
    task automatic watch(input int ncyc);
        logic       pass_prev;
        logic       fail_prev;
        logic [7:0] e;
        valid_cnt      = 0;
        err_cnt        = 0;
        first_lat      = -1;
        last_valid_cyc = -1000;
        pass_gap       = -1;
        fail_gap       = -1;
        align();
        pass_prev = pass_o;
        fail_prev = fail_o;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            if (rx_valid_o === 1'b1) begin
                valid_cnt++;
                if (first_lat < 0) first_lat = i;
                last_valid_cyc = i;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: got data %h, expected no valid", rx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data_o !== e) begin
                        failures++;
                        $display("FAIL rx_data: got %h, expected %h", rx_data_o, e);
                    end
                end
            end
            if (frame_err_o === 1'b1) err_cnt++;
            if (pass_o === 1'b1 && !pass_prev) pass_gap = i - last_valid_cyc;
            if (fail_o === 1'b1 && !fail_prev) fail_gap = i - last_valid_cyc;
            pass_prev = pass_o;
            fail_prev = fail_o;
        end
    endtask

    task automatic run_stream(input int nframes);
        fork
            send_stream();
            watch(nframes * 10 * Cpb + 4 * Cpb);
        join
    endtask

    task automatic do_reset();
        tx_q.delete();
        exp_q.delete();
        active_i = 1'b1;
        rx_i     = 1'b1;
        rst_ni   = 1'b0;
        repeat (3) align();
        rst_ni = 1'b1;
        repeat (2) align();
    endtask

    task automatic test_reset();
        rx_i   = 1'b1;
        rst_ni = 1'b0;
        #2;
        checks++;
        if ({rx_valid_o, rx_data_o, frame_err_o, byte_count_o, pass_o, fail_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b c=%0d p=%b f=%b, expected all 0",
                     rx_valid_o, rx_data_o, frame_err_o, byte_count_o, pass_o, fail_o);
        end
        do_reset();
    endtask

    task automatic test_single_byte();
        do_reset();
        tx_q.push_back({1'b1, 8'hA5});
        run_stream(1);
        checks++;
        if (valid_cnt !== 1) begin
            failures++; $display("FAIL single_valid_count: got %0d, expected 1", valid_cnt);
        end
        checks++;
        if (err_cnt !== 0) begin
            failures++; $display("FAIL single_frame_err: got %0d pulses, expected 0", err_cnt);
        end
        checks++;
        if (first_lat < 78 || first_lat > 80) begin
            failures++; $display("FAIL single_latency: got %0d, expected 78..80", first_lat);
        end
        checks++;
        if (byte_count_o !== 3'd1 || rx_data_o !== 8'hA5) begin
            failures++; $display("FAIL single_hold: got count %0d data %h, expected 1 a5", byte_count_o, rx_data_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL single_missing: got %0d bytes unreceived, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pass_marker();
        do_reset();
        push_str("xPASS\n");
        run_stream(6);
        checks++;
        if (pass_o !== 1'b1 || fail_o !== 1'b0) begin
            failures++; $display("FAIL pass_flags: got pass=%b fail=%b, expected 1 0", pass_o, fail_o);
        end
        checks++;
        if (pass_gap !== 1) begin
            failures++; $display("FAIL pass_timing: got gap %0d, expected 1", pass_gap);
        end
        checks++;
        if (byte_count_o !== 3'd6) begin
            failures++; $display("FAIL pass_count: got %0d, expected 6", byte_count_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL pass_missing: got %0d bytes unreceived, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_first_marker_wins();
        do_reset();
        push_str("PASSFAIL");
        run_stream(8);
        checks++;
        if (pass_o !== 1'b1 || fail_o !== 1'b0) begin
            failures++; $display("FAIL pass_then_fail: got pass=%b fail=%b, expected 1 0", pass_o, fail_o);
        end
        do_reset();
        push_str("FAILPASS");
        run_stream(8);
        checks++;
        if (fail_o !== 1'b1 || pass_o !== 1'b0) begin
            failures++; $display("FAIL fail_then_pass: got pass=%b fail=%b, expected 0 1", pass_o, fail_o);
        end
        checks++;
        if (fail_gap !== 1) begin
            failures++; $display("FAIL fail_timing: got gap %0d, expected 1", fail_gap);
        end
    endtask

    task automatic test_count_saturate();
        do_reset();
        push_str("abcdefghij");
        run_stream(10);
        checks++;
        if (byte_count_o !== 3'd7 || valid_cnt !== 10) begin
            failures++; $display("FAIL count_saturate: got count %0d valids %0d, expected 7 10", byte_count_o, valid_cnt);
        end
    endtask

    task automatic test_break();
        do_reset();
        fork
            begin
                align();
                send_byte(8'h33, 1'b0);
                hold_bits(1'b0, 30 * Cpb);
                hold_bits(1'b1, 2 * Cpb);
                exp_q.push_back(8'h41);
                send_byte(8'h41, 1'b1);
            end
            watch(10 * Cpb + 30 * Cpb + 2 * Cpb + 10 * Cpb + 4 * Cpb);
        join
        checks++;
        if (err_cnt !== 1) begin
            failures++; $display("FAIL break_err_pulses: got %0d, expected 1", err_cnt);
        end
        checks++;
        if (valid_cnt !== 1 || byte_count_o !== 3'd1) begin
            failures++; $display("FAIL break_valid: got valids %0d count %0d, expected 1 1", valid_cnt, byte_count_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL break_missing: got %0d bytes unreceived, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch_and_abort();
        do_reset();
        fork
            begin
                align();
                hold_bits(1'b0, 3);
                hold_bits(1'b1, 3 * Cpb);
                fork
                    send_byte(8'hFF, 1'b1);
                    begin
                        repeat (40) align();
                        active_i = 1'b0;
                        repeat (4) align();
                        active_i = 1'b1;
                    end
                join
                hold_bits(1'b1, Cpb);
                exp_q.push_back(8'h3C);
                send_byte(8'h3C, 1'b1);
            end
            watch(3 + 3 * Cpb + 10 * Cpb + Cpb + 10 * Cpb + 4 * Cpb);
        join
        checks++;
        if (valid_cnt !== 1 || err_cnt !== 0) begin
            failures++; $display("FAIL abort_pulses: got valids %0d errs %0d, expected 1 0", valid_cnt, err_cnt);
        end
        checks++;
        if (rx_data_o !== 8'h3C || byte_count_o !== 3'd1) begin
            failures++; $display("FAIL abort_recover: got data %h count %0d, expected 3c 1", rx_data_o, byte_count_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL abort_missing: got %0d bytes unreceived, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_stop();
        fork
            begin
                align();
                send_byte(8'h77, 1'b1);
            end
            begin
                align();
                repeat (75) align();
                rst_ni = 1'b0;
                #1;
                checks++;
                if ({rx_valid_o, rx_data_o, frame_err_o, byte_count_o, pass_o, fail_o} !== '0) begin
                    failures++;
                    $display("FAIL reset_mid_stop: got d=%h c=%0d v=%b e=%b, expected all 0",
                             rx_data_o, byte_count_o, rx_valid_o, frame_err_o);
                end
                repeat (2) align();
                rst_ni = 1'b1;
            end
        join
        tx_q.push_back({1'b1, 8'h5A});
        run_stream(1);
        checks++;
        if (rx_data_o !== 8'h5A || byte_count_o !== 3'd1 || valid_cnt !== 1) begin
            failures++; $display("FAIL after_reset: got data %h count %0d valids %0d, expected 5a 1 1",
                                 rx_data_o, byte_count_o, valid_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_pass_marker();
        test_first_marker_wins();
        test_count_saturate();
        test_break();
        test_glitch_and_abort();
        test_reset_mid_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
